// File: rtl/seg_pkg.sv
// Character codes and active-low 7-segment glyphs (bit6=g .. bit0=a) shared
// between the message scroller and the multiplexed display driver.
package seg_pkg;

  typedef logic [4:0] char_t;
  typedef logic [6:0] glyph_t;

  localparam int unsigned NUM_DIGITS = 4;

  localparam char_t CH_BLANK = 5'd16;
  localparam char_t CH_N     = 5'd17;
  localparam char_t CH_R     = 5'd18;
  localparam char_t CH_P     = 5'd19;
  localparam char_t CH_DASH  = 5'd20;

  localparam glyph_t GLYPH_0     = 7'b1000000;
  localparam glyph_t GLYPH_1     = 7'b1111001;
  localparam glyph_t GLYPH_2     = 7'b0100100;
  localparam glyph_t GLYPH_3     = 7'b0110000;
  localparam glyph_t GLYPH_4     = 7'b0011001;
  localparam glyph_t GLYPH_5     = 7'b0010010;
  localparam glyph_t GLYPH_6     = 7'b0000010;
  localparam glyph_t GLYPH_7     = 7'b1111000;
  localparam glyph_t GLYPH_8     = 7'b0000000;
  localparam glyph_t GLYPH_9     = 7'b0010000;
  localparam glyph_t GLYPH_A     = 7'b0001000;
  localparam glyph_t GLYPH_B     = 7'b0000011;
  localparam glyph_t GLYPH_C     = 7'b1000110;
  localparam glyph_t GLYPH_D     = 7'b0100001;
  localparam glyph_t GLYPH_E     = 7'b0000110;
  localparam glyph_t GLYPH_F     = 7'b0001110;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;
  localparam glyph_t GLYPH_N     = 7'b1001000;
  localparam glyph_t GLYPH_R     = 7'b1001100;
  localparam glyph_t GLYPH_P     = 7'b0001100;
  localparam glyph_t GLYPH_DASH  = 7'b0111111;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational character-code to active-low segment decoder.
// Unassigned codes show blank.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  char_t  code,
  output glyph_t glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      5'd0:    glyph = GLYPH_0;
      5'd1:    glyph = GLYPH_1;
      5'd2:    glyph = GLYPH_2;
      5'd3:    glyph = GLYPH_3;
      5'd4:    glyph = GLYPH_4;
      5'd5:    glyph = GLYPH_5;
      5'd6:    glyph = GLYPH_6;
      5'd7:    glyph = GLYPH_7;
      5'd8:    glyph = GLYPH_8;
      5'd9:    glyph = GLYPH_9;
      5'd10:   glyph = GLYPH_A;
      5'd11:   glyph = GLYPH_B;
      5'd12:   glyph = GLYPH_C;
      5'd13:   glyph = GLYPH_D;
      5'd14:   glyph = GLYPH_E;
      5'd15:   glyph = GLYPH_F;
      CH_N:    glyph = GLYPH_N;
      CH_R:    glyph = GLYPH_R;
      CH_P:    glyph = GLYPH_P;
      CH_DASH: glyph = GLYPH_DASH;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_msg_scroller.sv
// Message buffer with a four-character window that scrolls left at a fixed
// rate; the window is decoded into registered active-low segment patterns.
module seg_msg_scroller
  import seg_pkg::*;
#(
  parameter int unsigned MSG_DEPTH  = 16,
  parameter int unsigned STEP_TICKS = 400
) (
  input  logic                        segclk,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [4:0]                  wr_data,
  output logic                        wr_ready,
  input  logic                        clear_msg,
  input  logic                        run,
  output logic [$clog2(MSG_DEPTH):0]  msg_len,
  output logic                        wrap,
  output logic [6:0]                  glyph_l,
  output logic [6:0]                  glyph_ml,
  output logic [6:0]                  glyph_mr,
  output logic [6:0]                  glyph_r
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(STEP_TICKS);

  char_t           mem_q [MSG_DEPTH];
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   off_q, off_d;
  logic [LW-1:0]   off_inc;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;
  glyph_t          glyph_q [NUM_DIGITS];
  glyph_t          glyph_d [NUM_DIGITS];
  logic            wr_acc;
  logic            scroll_ok;

  assign wr_ready  = (len_q < LW'(MSG_DEPTH)) && !run && !clear_msg;
  assign wr_acc    = wr_en && wr_ready;
  assign scroll_ok = (len_q > LW'(NUM_DIGITS));
  assign off_inc   = off_q + LW'(1);

  // Length, scroll offset, step counter and wrap pulse.
  always_comb begin
    len_d  = len_q;
    off_d  = off_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear_msg) begin
      len_d = '0;
      off_d = '0;
      cnt_d = '0;
    end else if (wr_acc) begin
      len_d = len_q + LW'(1);
    end else if (!scroll_ok) begin
      off_d = '0;
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == CW'(STEP_TICKS - 1)) begin
        cnt_d = '0;
        // msg_len is arbitrary, so wrap by compare rather than bit overflow
        if (off_inc >= len_q) begin
          off_d  = '0;
          wrap_d = 1'b1;
        end else begin
          off_d = off_inc;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Window selection and decode for each digit position (0 = leftmost).
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [LW-1:0] sum;
    logic [AW-1:0] idx;
    char_t         code;

    assign sum = off_q + LW'(k);
    // offset < msg_len and k < msg_len, so one subtract yields the modulus
    assign idx = AW'((sum >= len_q) ? (sum - len_q) : sum);

    always_comb begin
      code = CH_BLANK;
      if (scroll_ok) begin
        code = mem_q[idx];
      end else if (LW'(k) < len_q) begin
        code = mem_q[AW'(k)];
      end
    end

    seg_glyph_decode u_decode (
      .code  (code),
      .glyph (glyph_d[k])
    );
  end

  // Character storage; contents are don't-care after reset.
  always_ff @(posedge segclk) begin
    if (wr_acc && !clr) begin
      mem_q[len_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      len_q  <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        glyph_q[k] <= GLYPH_BLANK;
      end
    end else begin
      len_q  <= len_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        glyph_q[k] <= glyph_d[k];
      end
    end
  end

  assign msg_len  = len_q;
  assign wrap     = wrap_q;
  assign glyph_l  = glyph_q[0];
  assign glyph_ml = glyph_q[1];
  assign glyph_mr = glyph_q[2];
  assign glyph_r  = glyph_q[3];

endmodule
